// File: rtl/w2_row_buffer.sv
// w2_row_buffer: receive end of the off-chip layer-2 weight write interface.
// Each row of weights is collected in a shadow bank. The row is then swapped
// into the active bank that the stage-2 MAC reads. The first row is promoted
// automatically. Later rows are promoted when the MAC signals consume_done.
module w2_row_buffer #(
    parameter int NUM_OUT = 10,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              w2SramWeOffChip,
    input  logic [ADDR_W-1:0] weight2AddrOffChip,
    input  logic [DATA_W-1:0] weight2,
    output logic              weight2_loadNextRow,
    input  logic              consume_done,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              row_valid,
    output logic [CNT_W-1:0]  row_count,
    output logic              wr_err
);

    localparam logic [ADDR_W-1:0] LP_NUM_OUT = ADDR_W'(NUM_OUT);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_RUN   = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_swap;

    logic [DATA_W-1:0]   r_shadow [NUM_OUT];
    logic [DATA_W-1:0]   r_active [NUM_OUT];
    logic [NUM_OUT-1:0]  r_mask;
    logic [CNT_W-1:0]    r_row_count;
    logic                r_wr_err;
    logic                r_load_pulse;
    logic [DATA_W-1:0]   r_rd_data;

    logic                w_full;
    logic                w_wr_addr_ok;
    logic                w_wr_accept;
    logic                w_wr_bad;
    logic                w_rd_addr_ok;

    // "full" is taken from the registered mask. A word written at one edge
    // therefore counts toward full starting at the next edge.
    assign w_full       = &r_mask;
    assign w_wr_addr_ok = (weight2AddrOffChip < LP_NUM_OUT);
    assign w_rd_addr_ok = (rd_addr < LP_NUM_OUT);

    // A write in the swap cycle goes into the freshly emptied shadow bank.
    // For that reason a full shadow only blocks writes when no swap happens.
    assign w_wr_accept  = w2SramWeOffChip && w_wr_addr_ok && (!w_full || w_swap);
    assign w_wr_bad     = w2SramWeOffChip && (!w_wr_addr_ok || (w_full && !w_swap));

    // Next-state logic and swap decision for the row promotion FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_swap      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_full) begin
                    w_swap      = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (consume_done) begin
                    if (w_full) begin
                        w_swap      = 1'b1;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (w_full) begin
                    w_swap      = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Shadow bank and its write mask. A swap clears the mask before the
    // same-cycle write sets its own bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mask <= '0;
            for (int i = 0; i < NUM_OUT; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            if (w_swap) begin
                r_mask <= '0;
            end
            if (w_wr_accept) begin
                r_shadow[weight2AddrOffChip] <= weight2;
                r_mask[weight2AddrOffChip]   <= 1'b1;
            end
        end
    end

    // Active bank. On a swap it takes the whole shadow bank as it stood
    // before this edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                r_active[i] <= '0;
            end
        end else if (w_swap) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                r_active[i] <= r_shadow[i];
            end
        end
    end

    // Row counter and the one-cycle "send next row" pulse that follows each swap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_row_count  <= '0;
            r_load_pulse <= 1'b0;
        end else begin
            r_load_pulse <= w_swap;
            if (w_swap) begin
                r_row_count <= r_row_count + CNT_W'(1);
            end
        end
    end

    // Sticky write error: a bad address, or a write into a full shadow bank
    // that is still waiting for its swap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_err <= 1'b0;
        end else if (w_wr_bad) begin
            r_wr_err <= 1'b1;
        end
    end

    // Registered read port. It returns the pre-swap active word, and 0 for
    // an out-of-range address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_data <= '0;
        end else if (w_rd_addr_ok) begin
            r_rd_data <= r_active[rd_addr];
        end else begin
            r_rd_data <= '0;
        end
    end

    assign weight2_loadNextRow = r_load_pulse;
    assign rd_data             = r_rd_data;
    assign row_valid           = (r_state == ST_RUN);
    assign row_count           = r_row_count;
    assign wr_err              = r_wr_err;

endmodule

// File: tb/tb_w2_row_buffer.sv
// Directed testbench for w2_row_buffer, with hand-computed expected values.
module tb_w2_row_buffer;

    logic        clk;
    logic        reset;
    logic        we;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic        load_next;
    logic        consume;
    logic [3:0]  raddr;
    logic [15:0] rdata;
    logic        rvalid;
    logic [7:0]  rcount;
    logic        werr;

    int n_vec;
    int n_err;

    w2_row_buffer #(
        .NUM_OUT(10),
        .DATA_W (16),
        .ADDR_W (4),
        .CNT_W  (8)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .w2SramWeOffChip    (we),
        .weight2AddrOffChip (waddr),
        .weight2            (wdata),
        .weight2_loadNextRow(load_next),
        .consume_done       (consume),
        .rd_addr            (raddr),
        .rd_data            (rdata),
        .row_valid          (rvalid),
        .row_count          (rcount),
        .wr_err             (werr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; outputs are then sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        tick();
        we    = 1'b0;
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        reset   = 1'b0;
        we      = 1'b0;
        waddr   = '0;
        wdata   = '0;
        consume = 1'b0;
        raddr   = '0;
        tick();
        tick();
        chk("rst_row_valid", rvalid, 0);
        chk("rst_row_count", rcount, 0);
        chk("rst_wr_err", werr, 0);
        chk("rst_rd_data", rdata, 0);
        chk("rst_load", load_next, 0);
        reset = 1'b1;
        tick();

        // Test 1: first row is auto-promoted.
        for (int i = 0; i < 10; i++) wr(4'(i), 16'(i + 1));
        chk("t1_valid_before", rvalid, 0);
        chk("t1_load_before", load_next, 0);
        tick();
        chk("t1_valid", rvalid, 1);
        chk("t1_load", load_next, 1);
        chk("t1_count", rcount, 1);
        raddr = 4'd3;
        tick();
        chk("t1_load_once", load_next, 0);
        chk("t1_rd3", rdata, 16'h0004);

        // Test 2: row B is swapped in by consume_done.
        for (int i = 0; i < 10; i++) wr(4'(i), 16'h1000 + 16'(i));
        tick();
        chk("t2_no_swap_count", rcount, 1);
        chk("t2_no_swap_load", load_next, 0);
        raddr   = 4'd0;
        consume = 1'b1;
        tick();
        consume = 1'b0;
        chk("t2_count", rcount, 2);
        chk("t2_load", load_next, 1);
        chk("t2_rd_preswap", rdata, 16'h0001);
        tick();
        chk("t2_rd0", rdata, 16'h1000);
        chk("t2_load_once", load_next, 0);

        // Test 3: consume_done on a partial shadow bank enters WAIT.
        for (int i = 0; i < 6; i++) wr(4'(i), 16'h2000 + 16'(i));
        consume = 1'b1;
        tick();
        consume = 1'b0;
        chk("t3_wait_valid", rvalid, 0);
        chk("t3_wait_load", load_next, 0);
        for (int i = 6; i < 10; i++) wr(4'(i), 16'h2000 + 16'(i));
        chk("t3_full_valid", rvalid, 0);
        raddr = 4'd7;
        tick();
        chk("t3_valid", rvalid, 1);
        chk("t3_count", rcount, 3);
        chk("t3_load", load_next, 1);
        tick();
        chk("t3_rd7", rdata, 16'h2007);

        // Test 4: a bad address and an overflow write are both dropped.
        chk("t4_err_clear", werr, 0);
        wr(4'hC, 16'hDEAD);
        chk("t4_err_addr", werr, 1);
        for (int i = 0; i < 10; i++) wr(4'(i), 16'h3000 + 16'(i));
        wr(4'd5, 16'hBEEF);
        chk("t4_err_sticky", werr, 1);
        consume = 1'b1;
        tick();
        consume = 1'b0;
        chk("t4_count", rcount, 4);
        raddr = 4'd5;
        tick();
        chk("t4_rd5_unchanged", rdata, 16'h3005);
        chk("t4_err_still", werr, 1);

        // Test 5: a write in the swap cycle goes into the new shadow bank.
        for (int i = 0; i < 10; i++) wr(4'(i), 16'h4000 + 16'(i));
        raddr   = 4'd2;
        consume = 1'b1;
        wr(4'd2, 16'h5555);
        consume = 1'b0;
        chk("t5_mask", dut.r_mask, 32'h004);
        chk("t5_count", rcount, 5);
        tick();
        chk("t5_active2", rdata, 16'h4002);
        raddr = 4'hB;
        tick();
        chk("t5_rd_oob", rdata, 0);

        // Test 6: an asynchronous reset in the middle of a fill.
        for (int i = 0; i < 5; i++) wr(4'(i), 16'h6000 + 16'(i));
        raddr = 4'd0;
        tick();
        reset = 1'b0;
        #1;
        chk("t6_rst_valid", rvalid, 0);
        chk("t6_rst_count", rcount, 0);
        chk("t6_rst_err", werr, 0);
        chk("t6_rst_rd", rdata, 0);
        chk("t6_rst_load", load_next, 0);
        #2;
        reset = 1'b1;
        for (int i = 0; i < 9; i++) wr(4'(i), 16'h7000 + 16'(i));
        tick();
        chk("t6_partial_valid", rvalid, 0);
        chk("t6_partial_load", load_next, 0);
        wr(4'd9, 16'h7009);
        tick();
        chk("t6_valid", rvalid, 1);
        chk("t6_count", rcount, 1);
        tick();
        chk("t6_rd0", rdata, 16'h7000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
